// File: rtl/tlb_fill_ctrl.sv
// tlb_fill_ctrl: shared I/D TLB refill controller with round-robin arbitration
//
// Fetches one PTE per miss through a single-outstanding memory port and writes
// the translation into the requesting TLB, or reports a page fault.
// Optional feature macro: TLB_FILL_STATS_EN adds saturating missCount/faultCount.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   iMissReq/iMissVAddr         instruction TLB miss request and address
//   dMissReq/dMissVAddr         data TLB miss request and address
//   ptBase                      page-table base physical address
//   iMissAck/dMissAck/fault     completion pulse per side, fault qualifies ack
//   memReq/memAddr              PTE read request, held until memAck
//   memAck/memData              PTE read response (PPN in high bits, bit0 valid)
//   iTlbWrite/dTlbWrite         one-cycle TLB write strobes
//   tlbVAddr/tlbPAddr           translation presented during the write strobe
//   missCount/faultCount        (TLB_FILL_STATS_EN only) saturating counters
module tlb_fill_ctrl #(
    parameter int ARCH_BITS = 32,
    parameter int PAGE_BITS = 12,
    parameter int PTE_BYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 iMissReq,
    input  logic [ARCH_BITS-1:0] iMissVAddr,
    input  logic                 dMissReq,
    input  logic [ARCH_BITS-1:0] dMissVAddr,
    input  logic [ARCH_BITS-1:0] ptBase,
    output logic                 iMissAck,
    output logic                 dMissAck,
    output logic                 fault,
    output logic                 memReq,
    output logic [ARCH_BITS-1:0] memAddr,
    input  logic                 memAck,
    input  logic [ARCH_BITS-1:0] memData,
    output logic                 iTlbWrite,
    output logic                 dTlbWrite,
    output logic [ARCH_BITS-1:0] tlbVAddr,
    output logic [ARCH_BITS-1:0] tlbPAddr
`ifdef TLB_FILL_STATS_EN
    ,
    output logic [15:0]          missCount,
    output logic [15:0]          faultCount
`endif
);
    typedef enum logic [1:0] {IDLE, FETCH, FILL, DONE} state_t;
    state_t state, nextState;
    logic sideD, lastD, faultFlag, grant, grantD, unusedPteBits;
    logic [ARCH_BITS-PAGE_BITS-1:0] ppn;
    logic [ARCH_BITS-1:0] selAddr, pteAddr;
    assign grant = iMissReq | dMissReq;
    // On a tie, serve whichever side was not granted last.
    assign grantD = dMissReq & (~iMissReq | ~lastD);
    assign selAddr = grantD ? dMissVAddr : iMissVAddr;
    // Sum is truncated to ARCH_BITS, so table walks wrap around the address space.
    assign pteAddr = ptBase + (selAddr >> PAGE_BITS) * ARCH_BITS'(PTE_BYTES);
    assign tlbPAddr = {ppn, tlbVAddr[PAGE_BITS-1:0]};
    assign unusedPteBits = ^memData[PAGE_BITS-1:1];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= nextState;
    end
    always_comb begin
        nextState = state;
        memReq = 1'b0;
        iTlbWrite = 1'b0;
        dTlbWrite = 1'b0;
        iMissAck = 1'b0;
        dMissAck = 1'b0;
        fault = 1'b0;
        case (state)
            IDLE: nextState = grant ? FETCH : IDLE;
            FETCH: begin
                memReq = 1'b1;
                nextState = !memAck ? FETCH : memData[0] ? FILL : DONE;
            end
            FILL: begin
                iTlbWrite = ~sideD;
                dTlbWrite = sideD;
                nextState = DONE;
            end
            default: begin
                iMissAck = ~sideD;
                dMissAck = sideD;
                fault = faultFlag;
                nextState = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sideD <= 1'b0;
            lastD <= 1'b1;
            faultFlag <= 1'b0;
            ppn <= '0;
            memAddr <= '0;
            tlbVAddr <= '0;
        end else if (state == IDLE && grant) begin
            sideD <= grantD;
            faultFlag <= 1'b0;
            memAddr <= pteAddr;
            tlbVAddr <= selAddr;
        end else if (state == FETCH && memAck) begin
            if (memData[0]) ppn <= memData[ARCH_BITS-1:PAGE_BITS];
            else faultFlag <= 1'b1;
        end else if (state == DONE) begin
            lastD <= sideD;
        end
    end
`ifdef TLB_FILL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            missCount <= '0;
            faultCount <= '0;
        end else begin
            if (state == IDLE && grant && missCount != 16'hFFFF) missCount <= missCount + 16'd1;
            if (state == DONE && faultFlag && faultCount != 16'hFFFF) faultCount <= faultCount + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_tlb_fill_ctrl.sv
// tb_tlb_fill_ctrl: directed self-checking bench for tlb_fill_ctrl
module tb_tlb_fill_ctrl;
    logic clk = 1'b0, rst = 1'b1;
    logic iMissReq = 1'b0, dMissReq = 1'b0, memAck = 1'b0;
    logic [31:0] iMissVAddr = '0, dMissVAddr = '0, ptBase = '0, memData = '0;
    logic iMissAck, dMissAck, fault, memReq, iTlbWrite, dTlbWrite;
    logic [31:0] memAddr, tlbVAddr, tlbPAddr;
`ifdef TLB_FILL_STATS_EN
    logic [15:0] missCount, faultCount;
`endif
    int nAsserts = 0, nFails = 0;
    tlb_fill_ctrl dut (
        .clk(clk), .rst(rst),
        .iMissReq(iMissReq), .iMissVAddr(iMissVAddr),
        .dMissReq(dMissReq), .dMissVAddr(dMissVAddr),
        .ptBase(ptBase),
        .iMissAck(iMissAck), .dMissAck(dMissAck), .fault(fault),
        .memReq(memReq), .memAddr(memAddr),
        .memAck(memAck), .memData(memData),
        .iTlbWrite(iTlbWrite), .dTlbWrite(dTlbWrite),
        .tlbVAddr(tlbVAddr), .tlbPAddr(tlbPAddr)
`ifdef TLB_FILL_STATS_EN
        ,
        .missCount(missCount), .faultCount(faultCount)
`endif
    );
    always #5 clk = ~clk;
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    // strobes = {memReq, iTlbWrite, dTlbWrite, iMissAck, dMissAck, fault}
    function automatic logic [5:0] strobes();
        return {memReq, iTlbWrite, dTlbWrite, iMissAck, dMissAck, fault};
    endfunction
    initial begin
        tick;
        tick;
        chk("reset_strobes", strobes(), 6'b000000);
        chk("reset_memAddr", memAddr, 32'h0);
        chk("reset_tlbVAddr", tlbVAddr, 32'h0);
        chk("reset_tlbPAddr", tlbPAddr, 32'h0);
`ifdef TLB_FILL_STATS_EN
        chk("reset_counts", {missCount, faultCount}, 32'h0);
`endif
        rst = 1'b0;
        // single I miss, W = 0
        iMissReq = 1'b1; iMissVAddr = 32'h0040_1234; ptBase = 32'h0010_0000;
        tick;
        chk("hit_c1_strobes", strobes(), 6'b100000);
        chk("hit_c1_memAddr", memAddr, 32'h0010_1004);
        memAck = 1'b1; memData = 32'h0008_8001;
        tick;
        memAck = 1'b0;
        chk("hit_c2_strobes", strobes(), 6'b010000);
        chk("hit_c2_tlbPAddr", tlbPAddr, 32'h0008_8234);
        chk("hit_c2_tlbVAddr", tlbVAddr, 32'h0040_1234);
        tick;
        chk("hit_c3_strobes", strobes(), 6'b000100);
        iMissReq = 1'b0;
        tick;
        chk("hit_c4_idle", strobes(), 6'b000000);
        // D fault
        dMissReq = 1'b1; dMissVAddr = 32'h1234_5000;
        tick;
        chk("flt_c1_memAddr", {strobes(), memAddr}, {6'b100000, 32'h0014_8D14});
        memAck = 1'b1; memData = 32'h0000_0000;
        tick;
        memAck = 1'b0;
        chk("flt_c2_strobes", strobes(), 6'b000011);
        dMissReq = 1'b0;
        tick;
        chk("flt_c3_idle", strobes(), 6'b000000);
        // simultaneous misses after reset: I first, then D wins the following tie
        rst = 1'b1;
        tick;
        rst = 1'b0;
        iMissReq = 1'b1; dMissReq = 1'b1;
        iMissVAddr = 32'h0040_1234; dMissVAddr = 32'h0080_2000;
        tick;
        chk("tie1_memAddr", {strobes(), memAddr}, {6'b100000, 32'h0010_1004});
        memAck = 1'b1; memData = 32'h0009_9001;
        tick;
        memAck = 1'b0;
        chk("tie1_iWrite", strobes(), 6'b010000);
        tick;
        chk("tie1_iAck", strobes(), 6'b000100);
        iMissVAddr = 32'h0040_3000;
        tick;
        chk("tie2_idle", strobes(), 6'b000000);
        tick;
        chk("tie2_dFirst", {strobes(), memAddr}, {6'b100000, 32'h0010_2008});
        memAck = 1'b1; memData = 32'h000A_A001;
        tick;
        memAck = 1'b0;
        chk("tie2_dWrite", {strobes(), tlbPAddr}, {6'b001000, 32'h000A_A000});
        tick;
        chk("tie2_dAck", strobes(), 6'b000010);
        dMissReq = 1'b0;
        tick;
        tick;
        chk("tie3_iServed", {strobes(), memAddr}, {6'b100000, 32'h0010_100C});
        memAck = 1'b1; memData = 32'h0;
        tick;
        memAck = 1'b0;
        chk("tie3_iFault", strobes(), 6'b000101);
        iMissReq = 1'b0;
        tick;
        // wait states W = 5
        iMissReq = 1'b1; iMissVAddr = 32'h0040_1234;
        tick;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("wait_c%0d", k), {strobes(), memAddr}, {6'b100000, 32'h0010_1004});
            tick;
        end
        chk("wait_c6", {strobes(), memAddr}, {6'b100000, 32'h0010_1004});
        memAck = 1'b1; memData = 32'h0008_8001;
        tick;
        memAck = 1'b0;
        chk("wait_c7_write", strobes(), 6'b010000);
        tick;
        chk("wait_c8_ack", strobes(), 6'b000100);
        iMissReq = 1'b0;
        tick;
        // address wrap
        dMissReq = 1'b1; dMissVAddr = 32'h0040_1000; ptBase = 32'hFFFF_F000;
        tick;
        chk("wrap_memAddr", memAddr, 32'h0000_0004);
        memAck = 1'b1; memData = 32'h0;
        tick;
        memAck = 1'b0;
        dMissReq = 1'b0;
        tick;
        // reset during FETCH, then a late memAck
        ptBase = 32'h0010_0000;
        iMissReq = 1'b1; iMissVAddr = 32'h0040_1234;
        tick;
        chk("rstf_fetch", strobes(), 6'b100000);
        rst = 1'b1;
        iMissReq = 1'b0;
        #2;
        chk("rstf_async", {strobes(), memAddr, tlbVAddr[25:0]}, 64'h0);
        rst = 1'b0;
        memAck = 1'b1; memData = 32'h0008_8001;
        tick;
        memAck = 1'b0;
        chk("rstf_noFill", strobes(), 6'b000000);
        tick;
        chk("rstf_noAck", strobes(), 6'b000000);
`ifdef TLB_FILL_STATS_EN
        chk("rstf_counts", {missCount, faultCount}, 32'h0);
`endif
        // one hit then one fault
        iMissReq = 1'b1;
        tick;
        memAck = 1'b1; memData = 32'h0008_8001;
        tick;
        memAck = 1'b0;
        tick;
        chk("st_hitAck", strobes(), 6'b000100);
        iMissReq = 1'b0;
        tick;
        dMissReq = 1'b1; dMissVAddr = 32'h1234_5000;
        tick;
        memAck = 1'b1; memData = 32'h0;
        tick;
        memAck = 1'b0;
        chk("st_faultAck", strobes(), 6'b000011);
        dMissReq = 1'b0;
        tick;
`ifdef TLB_FILL_STATS_EN
        chk("st_missCount", missCount, 16'd2);
        chk("st_faultCount", faultCount, 16'd1);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule

// File: doc/tlb_fill_ctrl.md
# tlb_fill_ctrl

Hardware TLB refill controller shared by the instruction and data TLBs. On a miss reported by either TLB, it arbitrates round-robin, fetches one page-table entry (PTE) from memory through a single-outstanding request/ack port, and writes the translation into the requesting TLB. It signals completion, or a page fault, back to the requester. It sits between the two TLBs, the pipeline stall logic and the memory arbiter.

## Interface
- ARCH_BITS, 32, virtual/physical address and data width
- PAGE_BITS, 12, page-offset bits; VPN = vAddr[ARCH_BITS-1:PAGE_BITS]
- PTE_BYTES, 4, PTE size in bytes; power of two

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- iMissReq  in  1  instruction TLB miss, level, held until iMissAck
- iMissVAddr  in  ARCH_BITS  faulting instruction virtual address
- dMissReq  in  1  data TLB miss, level, held until dMissAck
- dMissVAddr  in  ARCH_BITS  faulting data virtual address
- ptBase  in  ARCH_BITS  page-table base physical address
- iMissAck  out  1  one-cycle completion pulse to the instruction side
- dMissAck  out  1  one-cycle completion pulse to the data side
- fault  out  1  valid with an ack; 1 = PTE invalid, no fill done
- memReq  out  1  PTE read request, held until memAck
- memAddr  out  ARCH_BITS  PTE physical address
- memAck  in  1  one-cycle pulse; memData valid in the same cycle
- memData  in  ARCH_BITS  PTE: [ARCH_BITS-1:PAGE_BITS] = PPN, bit0 = valid
- iTlbWrite  out  1  one-cycle write strobe to the instruction TLB
- dTlbWrite  out  1  one-cycle write strobe to the data TLB
- tlbVAddr  out  ARCH_BITS  captured miss address (TLB vAddr during fill)
- tlbPAddr  out  ARCH_BITS  {PPN, vAddr[PAGE_BITS-1:0]}

## Operation
- FSM states: IDLE, FETCH, FILL, DONE. Reset state is IDLE.
- IDLE:
  - Arbitrates any asserted request.
  - If both requests are asserted, grants the side not granted last. The last-grant register resets to D, so I wins the first tie.
  - On grant: latches the side, the vAddr and ptBase. Sets memAddr = ptBase + VPN*PTE_BYTES, computed modulo 2^ARCH_BITS (carries out of the top bit are dropped). Moves to FETCH.
- FETCH:
  - memReq = 1 and memAddr is stable.
  - On memAck with memData[0] = 1: latches the PPN and moves to FILL.
  - On memAck with memData[0] = 0: sets the fault flag and moves to DONE.
- FILL:
  - Asserts the granted side's TLB write strobe for exactly one cycle.
  - tlbVAddr and tlbPAddr are valid during this cycle. Moves to DONE.
- DONE:
  - Pulses the granted side's ack for one cycle. fault is driven in the same cycle.
  - Updates the last-grant register and returns to IDLE.
- Requester rule: deassert the request at the edge that samples ack = 1. The controller does not check for a stale request.
- A request from the other side arriving during service waits in IDLE; it is not lost.
- Asynchronous reset mid-operation:
  - FSM returns to IDLE at once. All outputs drop to 0 and no fill occurs.
  - A memAck arriving after reset is ignored.
  - Requesters re-assert their misses after reset.

## Timing
- Reset values: iMissAck, dMissAck, fault, memReq, iTlbWrite, dTlbWrite = 0; memAddr, tlbVAddr, tlbPAddr = 0.
- All outputs are registered (driven from state/registers only); no combinational path from input to output.
- Cycle 0: request sampled in IDLE.
- Cycle 1: memReq = 1.
- Memory response: memAck at cycle 1+W, where W ≥ 0 wait cycles.
- Hit path: write strobe at cycle 2+W, ack at cycle 3+W. Minimum miss-to-ack latency is 3 cycles.
- Fault path: ack + fault at cycle 2+W, with no write strobe.
- Next grant is possible at cycle 4+W (hit) or 3+W (fault).
- memAck outside FETCH is ignored.

## Configuration
- TLB_FILL_STATS_EN defined:
  - Adds outputs missCount and faultCount, each 16 bits.
  - missCount increments on every grant. faultCount increments on every fault ack.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: the ports and logic are absent and behaviour is otherwise identical.

## Test plan
- Single I miss: iMissVAddr = 32'h0040_1234, ptBase = 32'h0010_0000, memAck at W = 0 with memData = 32'h0008_8001. Required: memAddr = 32'h0010_1004 at cycle 1, iTlbWrite at cycle 2 with tlbPAddr = 32'h0008_8234, iMissAck at cycle 3, fault = 0, dTlbWrite stays 0.
- Fault: dMissVAddr = 32'h1234_5000, memData = 32'h0000_0000. Required: dMissAck + fault at cycle 2+W, no write strobe.
- Simultaneous I and D misses after reset: I is served first, then D. On the next tie, D is served first.
- Wait states W = 5: memReq is held high for 6 cycles with memAddr stable; the ack arrives at cycle 8.
- Address wrap: ptBase = 32'hFFFF_F000, VPN = 32'h0000_0401. Required: memAddr = 32'h0000_0004.
- rst pulsed during FETCH, then memAck: all outputs go to 0, state is IDLE, and no write strobe or ack occurs.
- With TLB_FILL_STATS_EN defined, one hit followed by one fault gives missCount = 2 and faultCount = 1.
